// File: rtl/tick_sched.sv
// tick_sched: multi-channel tick-count timer scheduler with a round-robin valid/ready expiry event port.
// Optional feature macro: TICK_SCHED_PERIODIC_EN (periodic reload and sticky overrun flags).

module tick_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           tick_i,
  input  logic           cmd_valid_i,
  input  logic [1:0]     cmd_op_i,
  input  logic [CHW-1:0] cmd_ch_i,
  input  logic [CW-1:0]  cmd_ticks_i,
  output logic           evt_valid_o,
  input  logic           evt_ready_i,
  output logic [CHW-1:0] evt_ch_o,
  output logic [NCH-1:0] busy_o,
  output logic [NCH-1:0] ovr_o
);

  localparam logic [1:0] OP_ONESHOT  = 2'b00;
  localparam logic [1:0] OP_CANCEL   = 2'b01;
  localparam logic [1:0] OP_PERIODIC = 2'b10;
  localparam logic [1:0] OP_NOP      = 2'b11;

  typedef enum logic {
    EVT_EMPTY,
    EVT_FULL
  } evt_state_e;

  evt_state_e     state_q;
  logic [CHW-1:0] evt_ch_q;
  logic [CHW-1:0] rr_ptr_q;

  logic [NCH-1:0] run_q, run_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [CW-1:0]  rem_q [NCH];
  logic [CW-1:0]  rem_d [NCH];

`ifdef TICK_SCHED_PERIODIC_EN
  logic [NCH-1:0] per_q, per_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
`endif

  logic [NCH-1:0] cmd_hit;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] grant;
  logic           load;
  logic           win_found;
  logic [CHW-1:0] win_ch;
  logic [CHW-1:0] scan_idx;
  logic           is_cancel;
  logic           zero_start;

  always_comb begin
    cmd_hit    = '0;
    expire     = '0;
    is_cancel  = (cmd_op_i == OP_CANCEL);
    zero_start = (cmd_ticks_i == '0);
    for (int i = 0; i < NCH; i++) begin
      cmd_hit[i] = cmd_valid_i && (cmd_ch_i == CHW'(i)) && (cmd_op_i != OP_NOP);
      expire[i]  = tick_i && run_q[i] && (rem_q[i] == CW'(1));
    end
  end

  // Round-robin scan over registered pend flags, starting one past the last grant.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = rr_ptr_q + CHW'(k);
      if (!win_found && pend_q[scan_idx]) begin
        win_found = 1'b1;
        win_ch    = scan_idx;
      end
    end
  end

  assign load = (state_q == EVT_EMPTY) || evt_ready_i;

  always_comb begin
    grant = '0;
    if (load && win_found) begin
      grant[win_ch] = 1'b1;
    end
  end

  // Commands override expiry, and a same-cycle expiry keeps pend set even when granted.
  always_comb begin
    run_d  = run_q;
    pend_d = pend_q;
`ifdef TICK_SCHED_PERIODIC_EN
    per_d  = per_q;
    ovr_d  = ovr_q;
`endif
    for (int i = 0; i < NCH; i++) begin
      rem_d[i] = rem_q[i];
`ifdef TICK_SCHED_PERIODIC_EN
      period_d[i] = period_q[i];
`endif
      if (cmd_hit[i]) begin
        if (is_cancel) begin
          run_d[i]  = 1'b0;
          pend_d[i] = 1'b0;
`ifdef TICK_SCHED_PERIODIC_EN
          ovr_d[i]  = 1'b0;
`endif
        end else if (zero_start) begin
          run_d[i]  = 1'b0;
          pend_d[i] = 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
          ovr_d[i]  = 1'b0;
`endif
        end else begin
          run_d[i]  = 1'b1;
          pend_d[i] = 1'b0;
          rem_d[i]  = cmd_ticks_i;
`ifdef TICK_SCHED_PERIODIC_EN
          ovr_d[i]    = 1'b0;
          per_d[i]    = (cmd_op_i == OP_PERIODIC);
          period_d[i] = cmd_ticks_i;
`endif
        end
      end else if (expire[i]) begin
        pend_d[i] = 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
        if (pend_q[i] && !grant[i]) begin
          ovr_d[i] = 1'b1;
        end
        if (per_q[i]) begin
          rem_d[i] = period_q[i];
        end else begin
          run_d[i] = 1'b0;
        end
`else
        run_d[i] = 1'b0;
`endif
      end else begin
        if (tick_i && run_q[i] && (rem_q[i] > CW'(1))) begin
          rem_d[i] = rem_q[i] - CW'(1);
        end
        if (grant[i]) begin
          pend_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        rem_q[i] <= '0;
      end
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
      for (int i = 0; i < NCH; i++) begin
        rem_q[i] <= rem_d[i];
      end
    end
  end

`ifdef TICK_SCHED_PERIODIC_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_q <= '0;
      ovr_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
      end
    end else begin
      per_q <= per_d;
      ovr_q <= ovr_d;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
      end
    end
  end
`endif

  // Output register FSM: the presented channel only changes when empty or accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EVT_EMPTY;
      evt_ch_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        EVT_EMPTY: begin
          if (win_found) begin
            state_q  <= EVT_FULL;
            evt_ch_q <= win_ch;
            rr_ptr_q <= win_ch + CHW'(1);
          end
        end
        EVT_FULL: begin
          if (evt_ready_i) begin
            if (win_found) begin
              evt_ch_q <= win_ch;
              rr_ptr_q <= win_ch + CHW'(1);
            end else begin
              state_q <= EVT_EMPTY;
            end
          end
        end
        default: state_q <= EVT_EMPTY;
      endcase
    end
  end

  assign evt_valid_o = (state_q == EVT_FULL);
  assign evt_ch_o    = evt_ch_q;
  assign busy_o      = run_q;
`ifdef TICK_SCHED_PERIODIC_EN
  assign ovr_o       = ovr_q;
`else
  assign ovr_o       = '0;
`endif

endmodule
